// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC gain compensation stage.
// The constants are defaults for the module parameters.
package cordic_pkg;

  localparam int IN_W_DEF    = 9;
  localparam int OUT_W_DEF   = 8;
  localparam int PHASE_W_DEF = 32;
  localparam int K_Q15_DEF   = 19898;

  localparam logic signed [63:0] ROUND_Q15 = 64'sd16384;

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/cordic_out_fifo.sv
// First-word-fall-through FIFO for compensated CORDIC results.
// When empty, rdata holds the most recently popped entry, or zero after reset.
module cordic_out_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/cordic_gain_comp.sv
// Removes the CORDIC gain from x/y, rounds and saturates to OUT_W bits,
// and buffers results with the phase in an output FIFO.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int K_Q15      = K_Q15_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [IN_W-1:0]        x_in,
  input  logic signed [IN_W-1:0]        y_in,
  input  logic [PHASE_W-1:0]            phase_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       x_out,
  output logic signed [OUT_W-1:0]       y_out,
  output logic [PHASE_W-1:0]            phase_out,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int P_W     = IN_W + 16;
  localparam int ENTRY_W = 2 * OUT_W + PHASE_W;
  localparam logic signed [15:0] K_S = 16'(K_Q15);

  logic                     v_s1;
  logic signed [P_W-1:0]    p_x;
  logic signed [P_W-1:0]    p_y;
  logic [PHASE_W-1:0]       ph_s1;

  logic                     v_s2;
  logic signed [OUT_W-1:0]  x_s2;
  logic signed [OUT_W-1:0]  y_s2;
  logic [PHASE_W-1:0]       ph_s2;

  logic signed [63:0]       rnd_x;
  logic signed [63:0]       rnd_y;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  logic                     ovf_evt;
  logic [ENTRY_W-1:0]       fifo_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s1  <= 1'b0;
      p_x   <= '0;
      p_y   <= '0;
      ph_s1 <= '0;
    end else begin
      v_s1  <= in_valid;
      p_x   <= P_W'(x_in) * P_W'(K_S);
      p_y   <= P_W'(y_in) * P_W'(K_S);
      ph_s1 <= phase_in;
    end
  end

  // Round half up: add 2^14 then floor-shift by 15.
  always_comb begin
    rnd_x = (64'(p_x) + ROUND_Q15) >>> 15;
    rnd_y = (64'(p_y) + ROUND_Q15) >>> 15;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s2  <= 1'b0;
      x_s2  <= '0;
      y_s2  <= '0;
      ph_s2 <= '0;
    end else begin
      v_s2  <= v_s1;
      x_s2  <= OUT_W'(saturate(rnd_x, OUT_W));
      y_s2  <= OUT_W'(saturate(rnd_y, OUT_W));
      ph_s2 <= ph_s1;
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign ovf_evt   = v_s2 && fifo_full && !pop;

  cordic_out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v_s2),
    .pop   (pop),
    .wdata ({x_s2, y_s2, ph_s2}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign {x_out, y_out, phase_out} = fifo_rdata;

  // A new drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovf_evt) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Self-checking bench for cordic_gain_comp: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_cordic_gain_comp;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic signed [8:0] x_in;
  logic signed [8:0] y_in;
  logic [31:0]       phase_in;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] x_out;
  logic signed [7:0] y_out;
  logic [31:0]       phase_out;
  logic [3:0]        level;
  logic              overflow;
  logic              clr_ovf;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [31:0] ph;
  } sample_t;

  typedef struct {
    bit      valid;
    sample_t s;
  } flight_t;

  sample_t ref_q[$];
  flight_t pipe_q[$];
  sample_t last_out;
  logic    ref_ovf;

  int checks_total;
  int checks_passed;

  cordic_gain_comp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .y_in      (y_in),
    .phase_in  (phase_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .phase_out (phase_out),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // x * 0.60725 rounded half up, clamped to signed 8 bits.
  function automatic logic [7:0] comp_ref(input int v);
    real r;
    int  k;
    r = $floor(real'(v) * 19898.0 / 32768.0 + 0.5);
    k = $rtoi(r);
    if (k > 127) k = 127;
    if (k < -128) k = -128;
    return 8'(k);
  endfunction

  function automatic void model_reset();
    flight_t bubble;
    bubble.valid = 1'b0;
    bubble.s     = '0;
    ref_q.delete();
    pipe_q.delete();
    pipe_q.push_back(bubble);
    pipe_q.push_back(bubble);
    last_out = '0;
    ref_ovf  = 1'b0;
  endfunction

  function automatic void model_edge(input logic v, input int x, input int y,
                                     input logic [31:0] ph, input logic rdy, input logic clr);
    flight_t arriving;
    flight_t entering;
    logic    ovf_evt;
    entering.valid = v;
    entering.s.x   = comp_ref(x);
    entering.s.y   = comp_ref(y);
    entering.s.ph  = ph;
    arriving = pipe_q.pop_front();
    pipe_q.push_back(entering);
    if (ref_q.size() > 0 && rdy) begin
      last_out = ref_q.pop_front();
    end
    ovf_evt = 1'b0;
    if (arriving.valid) begin
      if (ref_q.size() < 8) ref_q.push_back(arriving.s);
      else ovf_evt = 1'b1;
    end
    if (ovf_evt) ref_ovf = 1'b1;
    else if (clr) ref_ovf = 1'b0;
  endfunction

  task automatic check_all();
    sample_t head;
    head = (ref_q.size() > 0) ? ref_q[0] : last_out;
    checkOutput("out_valid", out_valid, (ref_q.size() > 0));
    checkOutput("level", level, 64'(ref_q.size()));
    checkOutput("overflow", overflow, ref_ovf);
    checkOutput("x_out", $unsigned(x_out), head.x);
    checkOutput("y_out", $unsigned(y_out), head.y);
    checkOutput("phase_out", phase_out, head.ph);
  endtask

  // Called at a falling edge: drive, take one rising edge, then check.
  task automatic applyStimulus(input logic v, input logic signed [8:0] x, input logic signed [8:0] y,
                               input logic [31:0] ph, input logic rdy, input logic clr);
    in_valid  = v;
    x_in      = x;
    y_in      = y;
    phase_in  = ph;
    out_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    model_edge(v, x, y, ph, rdy, clr);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x_in      = '0;
    y_in      = '0;
    phase_in  = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();

    #12;
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_level", level, 4'd0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_x", $unsigned(x_out), 8'd0);
    checkOutput("rst_phase", phase_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic compensation");
    applyStimulus(1'b1, 9'sd100, -9'sd100, 32'h1234_5678, 1'b1, 1'b0);
    applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_valid", out_valid, 1'b1);
    checkOutput("t1_x", $unsigned(x_out), 8'd61);
    checkOutput("t1_y", $unsigned(y_out), 8'hC3);
    checkOutput("t1_phase", phase_out, 32'h1234_5678);
    applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_gone", out_valid, 1'b0);

    $display("[TB] saturation and small values");
    applyStimulus(1'b1, 9'sd255, -9'sd256, 32'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 9'sd1, 9'sd0, 32'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);
    checkOutput("sat_x", $unsigned(x_out), 8'd127);
    checkOutput("sat_y", $unsigned(y_out), 8'h80);
    applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);
    checkOutput("one_x", $unsigned(x_out), 8'd1);
    checkOutput("one_y", $unsigned(y_out), 8'd0);
    applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);

    $display("[TB] overflow and drain");
    for (int i = 1; i <= 10; i++)
      applyStimulus(1'b1, 9'(i * 10), 9'(-i * 5), 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovf_level", level, 4'd8);
    checkOutput("ovf_flag", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("drain_ph", phase_out, 32'(i));
      applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", out_valid, 1'b0);
    checkOutput("ovf_sticky", overflow, 1'b1);
    applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b0, 1'b1);
    checkOutput("ovf_clr", overflow, 1'b0);

    $display("[TB] full with simultaneous push and pop");
    for (int i = 1; i <= 10; i++)
      applyStimulus(1'b1, 9'(i), 9'(-i), 32'(i), 1'b0, 1'b0);
    for (int m = 1; m <= 20; m++) begin
      applyStimulus(1'b1, 9'(m + 10), 9'(-m), 32'(m + 10), 1'b1, 1'b0);
      checkOutput("full_level", level, 4'd8);
      checkOutput("full_ovf", overflow, 1'b0);
      checkOutput("full_order", phase_out, 32'(m + 1));
    end
    for (int i = 0; i < 11; i++)
      applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);

    $display("[TB] alternating valid");
    for (int j = 0; j < 9; j++) begin
      applyStimulus((j % 2 == 0) && (j < 6), 9'(j * 20), 9'(-j * 20), 32'(200 + j), 1'b1, 1'b0);
      if (j >= 2) begin
        checkOutput("alt_valid", out_valid, ((j - 2) % 2 == 0) && (j - 2 < 6));
        if (((j - 2) % 2 == 0) && (j - 2 < 6))
          checkOutput("alt_phase", phase_out, 32'(200 + j - 2));
      end
    end

    $display("[TB] reset mid-stream");
    for (int i = 1; i <= 7; i++)
      applyStimulus(1'b1, 9'(i * 30), 9'(i * 7), 32'(300 + i), 1'b0, 1'b0);
    checkOutput("pre_rst_level", level, 4'd5);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", out_valid, 1'b0);
    checkOutput("mid_rst_level", level, 4'd0);
    checkOutput("mid_rst_ovf", overflow, 1'b0);
    checkOutput("mid_rst_x", $unsigned(x_out), 8'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);
      checkOutput("post_rst_empty", out_valid, 1'b0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic signed [8:0] rx;
      logic signed [8:0] ry;
      rx = 9'($urandom_range(511, 0));
      ry = 9'($urandom_range(511, 0));
      applyStimulus($urandom_range(9, 0) < 7, rx, ry, $urandom,
                    $urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0);
    end
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b0, 9'sd0, 9'sd0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
